// File: rtl/rv64_pkg.sv
// Shared RV64 integer definitions: ALU select codes, opcodes
// and operand-source selectors used by issue and execute.
package rv64_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLT  = 5'd5,
        ALU_SLTU = 5'd6,
        ALU_SLL  = 5'd7,
        ALU_SRL  = 5'd8,
        ALU_SRA  = 5'd9,
        ALU_ADDW = 5'd10,
        ALU_SUBW = 5'd11,
        ALU_SLLW = 5'd12,
        ALU_SRLW = 5'd13,
        ALU_SRAW = 5'd14
    } alu_sel_e;

    typedef enum logic [1:0] {
        A_RS1,
        A_ZERO,
        A_PC
    } a_src_e;

    typedef enum logic {
        B_RS2,
        B_IMM
    } b_src_e;

    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;

    // Full-width OP/OP-IMM table; alt selects SUB/SRA
    function automatic alu_sel_e base_sel(
        input logic [2:0] f3,
        input logic       alt
    );
        alu_sel_e s;
        case (f3)
            3'b000:  s = alt ? ALU_SUB : ALU_ADD;
            3'b001:  s = ALU_SLL;
            3'b010:  s = ALU_SLT;
            3'b011:  s = ALU_SLTU;
            3'b100:  s = ALU_XOR;
            3'b101:  s = alt ? ALU_SRA : ALU_SRL;
            3'b110:  s = ALU_OR;
            default: s = ALU_AND;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Opcode/funct to ALU control translation for the issue stage.
// Purely combinational; also reports which sources are read.
module alu_ctrl_decode
    import rv64_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_sel_e   sel,
    output a_src_e     a_src,
    output b_src_e     b_src,
    output logic       rs1_used,
    output logic       rs2_used,
    output logic       illegal
);

    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        sel      = ALU_ADD;
        a_src    = A_RS1;
        b_src    = B_IMM;
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP: begin
                sel      = base_sel(funct3, funct7[5]);
                b_src    = B_RS2;
                rs2_used = 1'b1;
            end
            OP_IMM: begin
                // Immediate form has no SUBI; alt only picks SRAI
                sel = base_sel(funct3, funct7[5] && (funct3 == 3'b101));
            end
            OP_32, OP_IMM_32: begin
                case (funct3)
                    3'b000: sel = (funct7[5] && opcode == OP_32)
                                  ? ALU_SUBW : ALU_ADDW;
                    3'b001: sel = ALU_SLLW;
                    3'b101: sel = funct7[5] ? ALU_SRAW : ALU_SRLW;
                    default: illegal = 1'b1;
                endcase
                if (opcode == OP_32 && !illegal) begin
                    b_src    = B_RS2;
                    rs2_used = 1'b1;
                end
            end
            LUI: begin
                a_src    = A_ZERO;
                rs1_used = 1'b0;
            end
            AUIPC: begin
                a_src    = A_PC;
                rs1_used = 1'b0;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: operand forwarding, load-use bubbles and
// a registered valid/ready output feeding the 64-bit ALU.
module alu_issue_stage
    import rv64_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [4:0]       in_rs1_addr,
    input  logic [4:0]       in_rs2_addr,
    input  logic [4:0]       in_rd_addr,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic             ex_fwd_valid,
    input  logic [4:0]       ex_fwd_rd,
    input  logic [XLEN-1:0]  ex_fwd_data,
    input  logic             ex_fwd_is_load,
    input  logic             wb_fwd_valid,
    input  logic [4:0]       wb_fwd_rd,
    input  logic [XLEN-1:0]  wb_fwd_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [4:0]       alu_sel,
    output logic [4:0]       out_rd_addr,
    output logic             out_illegal,
    output logic [CNT_W-1:0] bubble_count
);

    alu_sel_e dec_sel;
    a_src_e   dec_a_src;
    b_src_e   dec_b_src;
    logic     rs1_used;
    logic     rs2_used;
    logic     dec_illegal;

    alu_ctrl_decode u_dec (
        .opcode   (in_opcode),
        .funct3   (in_funct3),
        .funct7   (in_funct7),
        .sel      (dec_sel),
        .a_src    (dec_a_src),
        .b_src    (dec_b_src),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used),
        .illegal  (dec_illegal)
    );

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  alu_a_q, alu_a_d;
    logic [XLEN-1:0]  alu_b_q, alu_b_d;
    alu_sel_e         alu_sel_q, alu_sel_d;
    logic [4:0]       rd_q, rd_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;

    logic            ex_hit1, ex_hit2, wb_hit1, wb_hit2;
    logic            hazard, out_free, accept;
    logic [XLEN-1:0] rs1_val, rs2_val, op_a, op_b;

    assign ex_hit1 = ex_fwd_valid && (ex_fwd_rd == in_rs1_addr);
    assign ex_hit2 = ex_fwd_valid && (ex_fwd_rd == in_rs2_addr);
    assign wb_hit1 = wb_fwd_valid && (wb_fwd_rd == in_rs1_addr);
    assign wb_hit2 = wb_fwd_valid && (wb_fwd_rd == in_rs2_addr);

    assign hazard = in_valid && ex_fwd_valid && ex_fwd_is_load
                 && (ex_fwd_rd != 5'd0)
                 && ((rs1_used && ex_fwd_rd == in_rs1_addr)
                  || (rs2_used && ex_fwd_rd == in_rs2_addr));

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = !hazard && out_free;
    assign accept   = in_valid && in_ready;

    // EX is younger than WB, so it wins; x0 always reads the RF value
    always_comb begin
        rs1_val = in_rs1_data;
        rs2_val = in_rs2_data;
        if (in_rs1_addr != 5'd0) begin
            if (ex_hit1)      rs1_val = ex_fwd_data;
            else if (wb_hit1) rs1_val = wb_fwd_data;
        end
        if (in_rs2_addr != 5'd0) begin
            if (ex_hit2)      rs2_val = ex_fwd_data;
            else if (wb_hit2) rs2_val = wb_fwd_data;
        end
        case (dec_a_src)
            A_ZERO:  op_a = '0;
            A_PC:    op_a = in_pc;
            default: op_a = rs1_val;
        endcase
        op_b = (dec_b_src == B_RS2) ? rs2_val : in_imm;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rd_d        = rd_q;
        illegal_d   = illegal_q;
        bubble_d    = bubble_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            alu_a_d     = op_a;
            alu_b_d     = op_b;
            alu_sel_d   = dec_sel;
            rd_d        = in_rd_addr;
            illegal_d   = dec_illegal;
        end else if (out_free) begin
            out_valid_d = 1'b0;
        end
        if (hazard && out_free && bubble_q != '1)
            bubble_d = bubble_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= ALU_ADD;
            rd_q        <= '0;
            illegal_q   <= 1'b0;
            bubble_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rd_q        <= rd_d;
            illegal_q   <= illegal_d;
            bubble_q    <= bubble_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_sel      = alu_sel_q;
    assign out_rd_addr  = rd_q;
    assign out_illegal  = illegal_q;
    assign bubble_count = bubble_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: reference model predicts
// each accepted instruction, directed tasks cover handshake corners.
module tb_alu_issue_stage;

    localparam int XLEN  = 64;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [4:0]       in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [XLEN-1:0]  in_rs1_data, in_rs2_data, in_imm;
    logic [6:0]       in_opcode;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic             ex_fwd_valid;
    logic [4:0]       ex_fwd_rd;
    logic [XLEN-1:0]  ex_fwd_data;
    logic             ex_fwd_is_load;
    logic             wb_fwd_valid;
    logic [4:0]       wb_fwd_rd;
    logic [XLEN-1:0]  wb_fwd_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  alu_a, alu_b;
    logic [4:0]       alu_sel;
    logic [4:0]       out_rd_addr;
    logic             out_illegal;
    logic [CNT_W-1:0] bubble_count;

    alu_issue_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_rs1_addr    (in_rs1_addr),
        .in_rs2_addr    (in_rs2_addr),
        .in_rd_addr     (in_rd_addr),
        .in_rs1_data    (in_rs1_data),
        .in_rs2_data    (in_rs2_data),
        .in_imm         (in_imm),
        .in_opcode      (in_opcode),
        .in_funct3      (in_funct3),
        .in_funct7      (in_funct7),
        .ex_fwd_valid   (ex_fwd_valid),
        .ex_fwd_rd      (ex_fwd_rd),
        .ex_fwd_data    (ex_fwd_data),
        .ex_fwd_is_load (ex_fwd_is_load),
        .wb_fwd_valid   (wb_fwd_valid),
        .wb_fwd_rd      (wb_fwd_rd),
        .wb_fwd_data    (wb_fwd_data),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_sel        (alu_sel),
        .out_rd_addr    (out_rd_addr),
        .out_illegal    (out_illegal),
        .bubble_count   (bubble_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]      sel;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            ill;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [4:0] optab(input logic [2:0] f3,
                                         input logic alt);
        case (f3)
            3'd0: return alt ? 5'd1 : 5'd0;
            3'd1: return 5'd7;
            3'd2: return 5'd5;
            3'd3: return 5'd6;
            3'd4: return 5'd4;
            3'd5: return alt ? 5'd9 : 5'd8;
            3'd6: return 5'd3;
            default: return 5'd2;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] fwd_m(input logic [4:0] addr,
                                              input logic [XLEN-1:0] rf);
        if (addr == 5'd0) return rf;
        if (ex_fwd_valid && ex_fwd_rd == addr) return ex_fwd_data;
        if (wb_fwd_valid && wb_fwd_rd == addr) return wb_fwd_data;
        return rf;
    endfunction

    function automatic exp_t model();
        exp_t e;
        logic alt;
        alt   = in_funct7[5];
        e.rd  = in_rd_addr;
        e.ill = 1'b0;
        e.sel = 5'd0;
        e.a   = fwd_m(in_rs1_addr, in_rs1_data);
        e.b   = in_imm;
        case (in_opcode)
            7'b0110011: begin
                e.sel = optab(in_funct3, alt);
                e.b   = fwd_m(in_rs2_addr, in_rs2_data);
            end
            7'b0010011: e.sel = optab(in_funct3, alt && in_funct3 == 3'd5);
            7'b0111011, 7'b0011011: begin
                if (in_funct3 == 3'd0)
                    e.sel = (alt && in_opcode == 7'b0111011) ? 5'd11 : 5'd10;
                else if (in_funct3 == 3'd1) e.sel = 5'd12;
                else if (in_funct3 == 3'd5) e.sel = alt ? 5'd14 : 5'd13;
                else e.ill = 1'b1;
                if (!e.ill && in_opcode == 7'b0111011)
                    e.b = fwd_m(in_rs2_addr, in_rs2_data);
            end
            7'b0110111: e.a = '0;
            7'b0010111: e.a = in_pc;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    exp_t mon_e;
    always @(posedge clk) begin
        if (rst) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got sel=%0d a=%0h, want none",
                             alu_sel, alu_a);
                end else begin
                    mon_e = sbq.pop_front();
                    if ({alu_sel, alu_a, alu_b, out_rd_addr, out_illegal} !== mon_e) begin
                        errors++;
                        $display("FAIL sb_out: got sel=%0d a=%0h b=%0h rd=%0d ill=%0b, want sel=%0d a=%0h b=%0h rd=%0d ill=%0b",
                                 alu_sel, alu_a, alu_b, out_rd_addr, out_illegal,
                                 mon_e.sel, mon_e.a, mon_e.b, mon_e.rd, mon_e.ill);
                    end
                end
            end else if (flush && out_valid && sbq.size() > 0) begin
                void'(sbq.pop_front());
            end
            if (in_valid && in_ready && !flush) sbq.push_back(model());
        end
    end

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [4:0] r1,
                             input logic [4:0] r2, input logic [4:0] rd,
                             input logic [XLEN-1:0] d1,
                             input logic [XLEN-1:0] d2,
                             input logic [XLEN-1:0] imm,
                             input logic [XLEN-1:0] pc);
        in_opcode   = op;
        in_funct3   = f3;
        in_funct7   = f7;
        in_rs1_addr = r1;
        in_rs2_addr = r2;
        in_rd_addr  = rd;
        in_rs1_data = d1;
        in_rs2_data = d2;
        in_imm      = imm;
        in_pc       = pc;
        in_valid    = 1'b1;
    endtask

    task automatic clear_fwd();
        ex_fwd_valid   = 1'b0;
        ex_fwd_rd      = '0;
        ex_fwd_data    = '0;
        ex_fwd_is_load = 1'b0;
        wb_fwd_valid   = 1'b0;
        wb_fwd_rd      = '0;
        wb_fwd_data    = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_illegal, alu_sel, out_rd_addr} !== 12'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got v=%0b ill=%0b sel=%0d rd=%0d, want 0",
                     out_valid, out_illegal, alu_sel, out_rd_addr);
        end
        checks++;
        if (alu_a !== '0 || alu_b !== '0) begin
            errors++;
            $display("FAIL reset_ops: got a=%0h b=%0h, want 0", alu_a, alu_b);
        end
        checks++;
        if (bubble_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_bubble: got %0d, want 0", bubble_count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sub();
        out_ready = 1'b1;
        set_instr(7'b0110011, 3'd0, 7'b0100000, 5'd1, 5'd2, 5'd3,
                  64'd10, 64'd3, 64'd0, 64'd0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || alu_sel !== 5'd1) begin
            errors++;
            $display("FAIL sub_ctrl: got v=%0b sel=%0d, want v=1 sel=1",
                     out_valid, alu_sel);
        end
        checks++;
        if (alu_a !== 64'd10 || alu_b !== 64'd3) begin
            errors++;
            $display("FAIL sub_ops: got a=%0d b=%0d, want a=10 b=3", alu_a, alu_b);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sub_drain: got v=%0b, want 0", out_valid);
        end
    endtask

    task automatic test_forward();
        ex_fwd_valid = 1'b1;
        ex_fwd_rd    = 5'd5;
        ex_fwd_data  = 64'hAA;
        wb_fwd_valid = 1'b1;
        wb_fwd_rd    = 5'd5;
        wb_fwd_data  = 64'hBB;
        set_instr(7'b0110011, 3'd0, 7'd0, 5'd5, 5'd6, 5'd8,
                  64'h11, 64'h22, 64'd0, 64'd0);
        @(negedge clk);
        checks++;
        if (alu_a !== 64'hAA) begin
            errors++;
            $display("FAIL fwd_ex_prio: got a=%0h, want aa", alu_a);
        end
        ex_fwd_rd = 5'd0;
        wb_fwd_rd = 5'd0;
        set_instr(7'b0110011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd9,
                  64'h123, 64'h456, 64'd0, 64'd0);
        @(negedge clk);
        checks++;
        if (alu_a !== 64'h123 || alu_b !== 64'h456) begin
            errors++;
            $display("FAIL fwd_x0: got a=%0h b=%0h, want a=123 b=456",
                     alu_a, alu_b);
        end
        ex_fwd_valid = 1'b0;
        wb_fwd_rd    = 5'd6;
        wb_fwd_data  = 64'hCC;
        set_instr(7'b0110011, 3'd6, 7'd0, 5'd2, 5'd6, 5'd9,
                  64'h5, 64'h456, 64'd0, 64'd0);
        @(negedge clk);
        checks++;
        if (alu_b !== 64'hCC || alu_sel !== 5'd3) begin
            errors++;
            $display("FAIL fwd_wb: got b=%0h sel=%0d, want b=cc sel=3",
                     alu_b, alu_sel);
        end
        in_valid = 1'b0;
        clear_fwd();
        @(negedge clk);
    endtask

    task automatic test_load_use();
        ex_fwd_valid   = 1'b1;
        ex_fwd_is_load = 1'b1;
        ex_fwd_rd      = 5'd7;
        ex_fwd_data    = 64'hDEAD;
        set_instr(7'b0110011, 3'd0, 7'd0, 5'd1, 5'd7, 5'd4,
                  64'h5, 64'h9, 64'd0, 64'd0);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL lu_ready: got %0b, want 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || bubble_count !== 3'd1) begin
            errors++;
            $display("FAIL lu_bubble: got v=%0b cnt=%0d, want v=0 cnt=1",
                     out_valid, bubble_count);
        end
        ex_fwd_valid   = 1'b0;
        ex_fwd_is_load = 1'b0;
        wb_fwd_valid   = 1'b1;
        wb_fwd_rd      = 5'd7;
        wb_fwd_data    = 64'h77;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lu_release: got %0b, want 1", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || alu_b !== 64'h77 || alu_a !== 64'h5) begin
            errors++;
            $display("FAIL lu_wbfwd: got v=%0b a=%0h b=%0h, want v=1 a=5 b=77",
                     out_valid, alu_a, alu_b);
        end
        in_valid = 1'b0;
        clear_fwd();
        @(negedge clk);
    endtask

    task automatic test_saturate();
        ex_fwd_valid   = 1'b1;
        ex_fwd_is_load = 1'b1;
        ex_fwd_rd      = 5'd3;
        set_instr(7'b0010011, 3'd0, 7'd0, 5'd3, 5'd0, 5'd4,
                  64'h1, 64'h0, 64'h4, 64'd0);
        repeat (8) @(negedge clk);
        checks++;
        if (bubble_count !== 3'd7 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bubble_sat: got cnt=%0d v=%0b, want cnt=7 v=0",
                     bubble_count, out_valid);
        end
        in_valid = 1'b0;
        clear_fwd();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops[4];
        logic [2:0] f3s[4];
        logic [6:0] f7s[4];
        ops[0] = 7'b0110011; f3s[0] = 3'd2; f7s[0] = 7'd0;
        ops[1] = 7'b0111011; f3s[1] = 3'd0; f7s[1] = 7'b0100000;
        ops[2] = 7'b0011011; f3s[2] = 3'd5; f7s[2] = 7'b0100000;
        ops[3] = 7'b0110111; f3s[3] = 3'd0; f7s[3] = 7'd0;
        out_ready = 1'b1;
        set_instr(7'b0010011, 3'd4, 7'd0, 5'd2, 5'd0, 5'd10,
                  64'hF0, 64'd0, 64'h0F, 64'd0);
        @(negedge clk);
        out_ready = 1'b0;
        set_instr(7'b0110011, 3'd7, 7'd0, 5'd3, 5'd4, 5'd11,
                  64'hFF00, 64'h0FF0, 64'd0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_sel !== 5'd4
                || alu_a !== 64'hF0 || alu_b !== 64'h0F
                || out_rd_addr !== 5'd10) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%0b rdy=%0b sel=%0d a=%0h b=%0h rd=%0d, want v=1 rdy=0 sel=4 a=f0 b=f rd=10",
                         i, out_valid, in_ready, alu_sel, alu_a, alu_b,
                         out_rd_addr);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %0b, want 1", i, in_ready);
            end
            @(negedge clk);
            set_instr(ops[i], f3s[i], f7s[i], 5'(i + 1), 5'(i + 2),
                      5'(i + 12), 64'($urandom), 64'($urandom),
                      64'($urandom), 64'($urandom));
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (sbq.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got pending=%0d v=%0b, want 0 0",
                     sbq.size(), out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_instr(7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd5,
                  64'h10, 64'h20, 64'd0, 64'd0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre: got v=%0b, want 1", out_valid);
        end
        flush = 1'b1;
        set_instr(7'b0110011, 3'd4, 7'd0, 5'd1, 5'd2, 5'd6,
                  64'h30, 64'h40, 64'd0, 64'd0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_kill: got v=%0b, want 0", out_valid);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: got v=%0b, want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        set_instr(7'b0110011, 3'd1, 7'd0, 5'd1, 5'd2, 5'd7,
                  64'h99, 64'h3, 64'd0, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || alu_sel !== 5'd7) begin
            errors++;
            $display("FAIL rst_pre: got v=%0b sel=%0d, want v=1 sel=7",
                     out_valid, alu_sel);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, out_illegal, alu_sel, out_rd_addr} !== 12'd0
            || alu_a !== '0 || alu_b !== '0 || bubble_count !== 3'd0) begin
            errors++;
            $display("FAIL rst_stall: got v=%0b sel=%0d a=%0h b=%0h rd=%0d cnt=%0d, want all 0",
                     out_valid, alu_sel, alu_a, alu_b, out_rd_addr,
                     bubble_count);
        end
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        set_instr(7'b1100011, 3'd0, 7'd0, 5'd3, 5'd4, 5'd0,
                  64'h33, 64'h44, 64'h10, 64'd0);
        @(negedge clk);
        checks++;
        if (out_illegal !== 1'b1 || alu_sel !== 5'd0 || alu_a !== 64'h33
            || alu_b !== 64'h10) begin
            errors++;
            $display("FAIL illegal_br: got ill=%0b sel=%0d a=%0h b=%0h, want ill=1 sel=0 a=33 b=10",
                     out_illegal, alu_sel, alu_a, alu_b);
        end
        set_instr(7'b0010111, 3'd0, 7'd0, 5'd9, 5'd0, 5'd1,
                  64'h55, 64'd0, 64'h2000, 64'h1000);
        @(negedge clk);
        checks++;
        if (alu_a !== 64'h1000 || alu_b !== 64'h2000 || alu_sel !== 5'd0
            || out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL auipc: got a=%0h b=%0h sel=%0d ill=%0b, want a=1000 b=2000 sel=0 ill=0",
                     alu_a, alu_b, alu_sel, out_illegal);
        end
        set_instr(7'b0111011, 3'd2, 7'd0, 5'd1, 5'd2, 5'd3,
                  64'h7, 64'h8, 64'h9, 64'd0);
        @(negedge clk);
        checks++;
        if (out_illegal !== 1'b1 || alu_b !== 64'h9) begin
            errors++;
            $display("FAIL illegal_op32: got ill=%0b b=%0h, want ill=1 b=9",
                     out_illegal, alu_b);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        set_instr('0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
        in_valid = 1'b0;
        clear_fwd();
        @(negedge clk);
        test_reset();
        test_sub();
        test_forward();
        test_load_use();
        test_saturate();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        test_illegal();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending, want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX pipeline stage directly upstream of the 64-bit execute ALU. It accepts one decoded integer instruction per cycle and resolves operands through the EX and WB forwarding paths. It translates opcode/funct fields into the 5-bit ALU select and presents registered `alu_a`/`alu_b`/`alu_sel` with a valid/ready handshake. It also detects load-use hazards, inserts bubbles, and counts them.

## Interface
- `XLEN`, 64: operand width.
- `CNT_W`, 32: bubble-counter width.
- `clk` in 1: single clock. All state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `in_pc` in XLEN: instruction PC.
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr` in 5: register indices.
- `in_rs1_data`, `in_rs2_data` in XLEN: register-file read data.
- `in_imm` in XLEN: sign-extended immediate from decode.
- `in_opcode` in 7, `in_funct3` in 3, `in_funct7` in 7: raw instruction fields.
- `ex_fwd_valid` in 1, `ex_fwd_rd` in 5, `ex_fwd_data` in XLEN, `ex_fwd_is_load` in 1: EX/MEM producer.
- `wb_fwd_valid` in 1, `wb_fwd_rd` in 5, `wb_fwd_data` in XLEN: WB producer.
- `flush` in 1: kill held and incoming instruction.
- `out_valid` out 1: ALU operands valid.
- `out_ready` in 1: execute consumes.
- `alu_a`, `alu_b` out XLEN: ALU operands.
- `alu_sel` out 5: ALU operation.
- `out_rd_addr` out 5: destination register.
- `out_illegal` out 1: opcode not handled by ALU path.
- `bubble_count` out CNT_W: saturating load-use bubble count.

## Operation
- Opcode handling and ALU select:
  - OP (0110011): funct3 000 gives ADD, or SUB when funct7[5]=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7[5]=1; 110 OR; 111 AND.
  - OP-IMM (0010011): same table, except funct3 000 is always ADD.
  - OP-32 (0111011): 000 ADDW/SUBW; 001 SLLW; 101 SRLW/SRAW.
  - OP-IMM-32 (0011011): 000 ADDW; 001 SLLW; 101 SRLW/SRAW.
- ALU select encodings: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, ADDW 10, SUBW 11, SLLW 12, SRLW 13, SRAW 14.
- Operand selection:
  - `a`: rs1 for OP and the three other register/immediate ALU classes; 0 for LUI (0110111); pc for AUIPC (0010111).
  - `b`: rs2 for OP and OP-32; imm otherwise.
  - LUI and AUIPC use ADD.
- Illegal instructions: any other opcode, or an unlisted funct3 under OP-32/OP-IMM-32. The instruction still passes through with `alu_sel`=ADD, `out_illegal`=1, a=rs1, b=imm.
- Source usage:
  - rs1 is used unless LUI/AUIPC.
  - rs2 is used only for OP and OP-32.
- Forwarding, per used source with a non-zero address:
  - EX match (`ex_fwd_valid` and rd equal) takes priority over WB match.
  - Otherwise register-file data is used.
  - x0 is never forwarded.
- Load-use hazard: `in_valid`, plus `ex_fwd_valid`, `ex_fwd_is_load`, a non-zero `ex_fwd_rd` matching a used source.
  - The instruction is not accepted (`in_ready`=0).
  - If the output register is free this cycle, a bubble is loaded (`out_valid`=0).
  - `bubble_count` increments once per bubble cycle and saturates at all-ones.

## Timing
- Latency: 1 cycle. Outputs are registered; an input accepted at edge N appears at edge N+1.
- Accept rule: `in_ready` = !hazard && (!out_valid || out_ready). Full throughput with no bubble when `out_ready` is held at 1.
- Stall: `out_valid`=1 and `out_ready`=0 hold all outputs stable. Held operands are never re-forwarded.
- Flush: `out_valid` is 0 next cycle, the input is dropped, and flush overrides acceptance. `bubble_count` is unaffected by flush.
- Reset: `out_valid`=0, `alu_a`=`alu_b`=0, `alu_sel`=0, `out_rd_addr`=0, `out_illegal`=0, `bubble_count`=0. Reset overrides flush and hazard.
- Combinational paths: `in_ready` depends combinationally on `out_ready`, `ex_fwd_*` and the input fields. No output depends combinationally on inputs otherwise.

## Structure
- Shared `rv64_pkg`:
  - `alu_sel_e` enum with the codes above, shared with the ALU.
  - Opcode constants OP, OP_IMM, OP_32, OP_IMM_32, LUI, AUIPC.
- Sub-module `alu_ctrl_decode`: combinational mapping of opcode/funct3/funct7 to sel, a_src, b_src, rs1_used, rs2_used and illegal.
- Forwarding, hazard detection, the handshake register and the counter live in the top module.

## Test plan
- OP SUB, funct7=0100000, rs1=10, rs2=3, no forwarding, out_ready=1: next cycle `alu_sel`=1, a=10, b=3, `out_valid`=1.
- OP ADD with rs1=x5, EX fwd rd=5 data=0xAA, WB fwd rd=5 data=0xBB: a=0xAA.
  - Same with rd=0 everywhere: a=`in_rs1_data`.
- EX load to x7, then OP using rs2=x7:
  - `in_ready`=0 for 1 cycle, `out_valid`=0, `bubble_count`=1.
  - Next cycle accepted with WB-forwarded data.
- `out_ready`=0 for 3 cycles with `out_valid`=1: outputs unchanged, `in_ready`=0. On release, back-to-back accepts at 1/cycle.
- Flush asserted with `in_valid`=1 and a held output: next cycle `out_valid`=0.
  - Separately, reset mid-stall: all outputs zero.
- Opcode 1100011 (branch): `out_illegal`=1, `alu_sel`=0.
  - AUIPC pc=0x1000, imm=0x2000: a=0x1000, b=0x2000, sel=0.
